// File: rtl/axi_lite_addr_router.sv
// AXI-lite slave-side address decoder: steers AW/W/B and AR/R to one of four
// targets by address, with an internal error responder and miss bookkeeping.
module axi_lite_addr_router #(
  parameter logic [31:0] S0_BASE  = 32'h0000_0000,
  parameter logic [31:0] S0_MASK  = 32'hFFFF_0000,
  parameter logic [31:0] S1_BASE  = 32'h1000_0000,
  parameter logic [31:0] S1_MASK  = 32'hFFFF_0000,
  parameter logic [31:0] S2_BASE  = 32'h2000_0000,
  parameter logic [31:0] S2_MASK  = 32'hFFFF_F000,
  parameter logic [31:0] S3_BASE  = 32'h2000_1000,
  parameter logic [31:0] S3_MASK  = 32'hFFFF_F000,
  parameter logic [31:0] ERR_DATA = 32'hBADA_DD00
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [31:0]  s_awaddr,
  input  logic         s_awvalid,
  output logic         s_awready,
  input  logic [31:0]  s_wdata,
  input  logic [3:0]   s_wstrb,
  input  logic         s_wvalid,
  output logic         s_wready,
  output logic         s_bvalid,
  input  logic         s_bready,
  input  logic [31:0]  s_araddr,
  input  logic         s_arvalid,
  output logic         s_arready,
  output logic [31:0]  s_rdata,
  output logic         s_rvalid,
  input  logic         s_rready,
  output logic [127:0] m_awaddr,
  output logic [127:0] m_wdata,
  output logic [15:0]  m_wstrb,
  output logic [3:0]   m_awvalid,
  output logic [3:0]   m_wvalid,
  output logic [3:0]   m_bready,
  output logic [3:0]   m_arvalid,
  output logic [3:0]   m_rready,
  input  logic [3:0]   m_awready,
  input  logic [3:0]   m_wready,
  input  logic [3:0]   m_bvalid,
  input  logic [3:0]   m_arready,
  input  logic [3:0]   m_rvalid,
  output logic [127:0] m_araddr,
  input  logic [127:0] m_rdata,
  input  logic         err_clr,
  output logic [7:0]   err_count,
  output logic [31:0]  last_err_addr
);

  typedef enum logic [1:0] {WR_IDLE, WR_DATA, WR_RESP} wrState_t;
  typedef enum logic [0:0] {RD_IDLE, RD_RESP} rdState_t;

  wrState_t    r_wrState;
  rdState_t    r_rdState;
  logic [2:0]  r_wSel;
  logic [2:0]  r_rSel;
  logic        r_wDone;
  logic [7:0]  r_errCount;
  logic [31:0] r_lastErrAddr;

  logic [2:0]  w_awSel;
  logic [2:0]  w_arSel;
  logic        w_awMiss;
  logic        w_arMiss;
  logic        w_wSelMiss;
  logic        w_rSelMiss;
  logic        w_awHs;
  logic        w_wHs;
  logic        w_bHs;
  logic        w_arHs;
  logic        w_rHs;
  logic        w_wrMiss;
  logic        w_rdMiss;
  logic [1:0]  w_errInc;
  logic [8:0]  w_errSum;

  // Select encoding: bit 2 set means the error responder, else [1:0] is the target.
  function automatic logic [2:0] decode(input logic [31:0] addr);
    if ((addr & S0_MASK) == S0_BASE)      return 3'd0;
    else if ((addr & S1_MASK) == S1_BASE) return 3'd1;
    else if ((addr & S2_MASK) == S2_BASE) return 3'd2;
    else if ((addr & S3_MASK) == S3_BASE) return 3'd3;
    else                                  return 3'd4;
  endfunction

  assign w_awSel    = decode(s_awaddr);
  assign w_arSel    = decode(s_araddr);
  assign w_awMiss   = w_awSel[2];
  assign w_arMiss   = w_arSel[2];
  assign w_wSelMiss = r_wSel[2];
  assign w_rSelMiss = r_rSel[2];

  assign m_awaddr = {4{s_awaddr}};
  assign m_wdata  = {4{s_wdata}};
  assign m_wstrb  = {4{s_wstrb}};
  assign m_araddr = {4{s_araddr}};

  // Write channel steering; valids are held low while reset is asserted.
  always_comb begin
    m_awvalid = '0;
    m_wvalid  = '0;
    m_bready  = '0;
    s_awready = 1'b0;
    s_wready  = 1'b0;
    s_bvalid  = 1'b0;
    case (r_wrState)
      WR_IDLE: begin
        s_awready = w_awMiss ? 1'b1 : m_awready[w_awSel[1:0]];
        if (!w_awMiss) m_awvalid[w_awSel[1:0]] = s_awvalid & ~rst;
        if (s_awvalid && !r_wDone) begin
          s_wready = w_awMiss ? 1'b1 : m_wready[w_awSel[1:0]];
          if (!w_awMiss) m_wvalid[w_awSel[1:0]] = s_wvalid & ~rst;
        end
      end
      WR_DATA: begin
        s_wready = w_wSelMiss ? 1'b1 : m_wready[r_wSel[1:0]];
        if (!w_wSelMiss) m_wvalid[r_wSel[1:0]] = s_wvalid;
      end
      WR_RESP: begin
        s_bvalid = w_wSelMiss ? 1'b1 : m_bvalid[r_wSel[1:0]];
        if (!w_wSelMiss) m_bready[r_wSel[1:0]] = s_bready;
      end
      default: ;
    endcase
  end

  assign w_awHs = (r_wrState == WR_IDLE) && s_awvalid && s_awready;
  assign w_wHs  = s_wvalid && s_wready;
  assign w_bHs  = s_bvalid && s_bready;

  // A W beat accepted ahead of its AW is remembered so the burst skips WR_DATA.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wrState <= WR_IDLE;
      r_wSel    <= '0;
      r_wDone   <= 1'b0;
    end else begin
      case (r_wrState)
        WR_IDLE: begin
          if (w_awHs) begin
            r_wSel    <= w_awSel;
            r_wDone   <= 1'b0;
            r_wrState <= (w_wHs || r_wDone) ? WR_RESP : WR_DATA;
          end else if (w_wHs) begin
            r_wDone <= 1'b1;
          end
        end
        WR_DATA: if (w_wHs) r_wrState <= WR_RESP;
        WR_RESP: if (w_bHs) r_wrState <= WR_IDLE;
        default: r_wrState <= WR_IDLE;
      endcase
    end
  end

  always_comb begin
    m_arvalid = '0;
    m_rready  = '0;
    s_arready = 1'b0;
    s_rvalid  = 1'b0;
    s_rdata   = w_rSelMiss ? ERR_DATA : m_rdata[{r_rSel[1:0], 5'd0} +: 32];
    case (r_rdState)
      RD_IDLE: begin
        s_arready = w_arMiss ? 1'b1 : m_arready[w_arSel[1:0]];
        if (!w_arMiss) m_arvalid[w_arSel[1:0]] = s_arvalid & ~rst;
      end
      RD_RESP: begin
        s_rvalid = w_rSelMiss ? 1'b1 : m_rvalid[r_rSel[1:0]];
        if (!w_rSelMiss) m_rready[r_rSel[1:0]] = s_rready;
      end
      default: ;
    endcase
  end

  assign w_arHs = (r_rdState == RD_IDLE) && s_arvalid && s_arready;
  assign w_rHs  = s_rvalid && s_rready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rdState <= RD_IDLE;
      r_rSel    <= '0;
    end else begin
      case (r_rdState)
        RD_IDLE: begin
          if (w_arHs) begin
            r_rSel    <= w_arSel;
            r_rdState <= RD_RESP;
          end
        end
        RD_RESP: if (w_rHs) r_rdState <= RD_IDLE;
        default: r_rdState <= RD_IDLE;
      endcase
    end
  end

  assign w_wrMiss = w_awHs && w_awMiss;
  assign w_rdMiss = w_arHs && w_arMiss;
  assign w_errInc = {1'b0, w_wrMiss} + {1'b0, w_rdMiss};
  assign w_errSum = {1'b0, r_errCount} + {7'd0, w_errInc};

  // Clear beats any same-cycle miss; the captured address still updates.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_errCount    <= '0;
      r_lastErrAddr <= '0;
    end else begin
      if (err_clr)          r_errCount <= '0;
      else if (w_errSum[8]) r_errCount <= 8'hFF;
      else                  r_errCount <= w_errSum[7:0];
      if (w_rdMiss)         r_lastErrAddr <= s_araddr;
      else if (w_wrMiss)    r_lastErrAddr <= s_awaddr;
    end
  end

  assign err_count     = r_errCount;
  assign last_err_addr = r_lastErrAddr;

endmodule

// File: tb/tb_axi_lite_addr_router.sv
// Self-checking bench for axi_lite_addr_router: directed scenarios plus random
// traffic, checked against an address-map and miss-counter reference model.
module tb_axi_lite_addr_router;

  logic         clk;
  logic         rst;
  logic [31:0]  s_awaddr;
  logic         s_awvalid;
  logic         s_awready;
  logic [31:0]  s_wdata;
  logic [3:0]   s_wstrb;
  logic         s_wvalid;
  logic         s_wready;
  logic         s_bvalid;
  logic         s_bready;
  logic [31:0]  s_araddr;
  logic         s_arvalid;
  logic         s_arready;
  logic [31:0]  s_rdata;
  logic         s_rvalid;
  logic         s_rready;
  logic [127:0] m_awaddr;
  logic [127:0] m_wdata;
  logic [15:0]  m_wstrb;
  logic [3:0]   m_awvalid;
  logic [3:0]   m_wvalid;
  logic [3:0]   m_bready;
  logic [3:0]   m_arvalid;
  logic [3:0]   m_rready;
  logic [3:0]   m_awready;
  logic [3:0]   m_wready;
  logic [3:0]   m_bvalid;
  logic [3:0]   m_arready;
  logic [3:0]   m_rvalid;
  logic [127:0] m_araddr;
  logic [127:0] m_rdata;
  logic         err_clr;
  logic [7:0]   err_count;
  logic [31:0]  last_err_addr;

  int          nCompared = 0;
  int          nMismatch = 0;
  int          expCount  = 0;
  logic [31:0] expLast   = '0;
  localparam logic [31:0] ERR_DATA = 32'hBADA_DD00;

  axi_lite_addr_router dut (
    .clk(clk), .rst(rst),
    .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
    .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
    .s_bvalid(s_bvalid), .s_bready(s_bready),
    .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
    .s_rdata(s_rdata), .s_rvalid(s_rvalid), .s_rready(s_rready),
    .m_awaddr(m_awaddr), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
    .m_awvalid(m_awvalid), .m_wvalid(m_wvalid), .m_bready(m_bready),
    .m_arvalid(m_arvalid), .m_rready(m_rready),
    .m_awready(m_awready), .m_wready(m_wready), .m_bvalid(m_bvalid),
    .m_arready(m_arready), .m_rvalid(m_rvalid),
    .m_araddr(m_araddr), .m_rdata(m_rdata),
    .err_clr(err_clr), .err_count(err_count), .last_err_addr(last_err_addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Address map straight from the target table; lowest index wins.
  function automatic int tbDecode(input logic [31:0] a);
    if ((a & 32'hFFFF_0000) == 32'h0000_0000) return 0;
    if ((a & 32'hFFFF_0000) == 32'h1000_0000) return 1;
    if ((a & 32'hFFFF_F000) == 32'h2000_0000) return 2;
    if ((a & 32'hFFFF_F000) == 32'h2000_1000) return 3;
    return 4;
  endfunction

  function automatic logic [3:0] oneHot(input int t);
    return (t < 4) ? 4'(1 << t) : 4'b0000;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic noteMiss(input logic [31:0] addr);
    if (err_clr) expCount = 0;
    else expCount = (expCount >= 255) ? 255 : expCount + 1;
    expLast = addr;
  endtask

  task automatic checkCounters(input string tag);
    nCompared++; if (err_count !== 8'(expCount)) begin nMismatch++; $display("[TB] FAIL %s err_count: got %0d expected %0d", tag, err_count, expCount); end
    nCompared++; if (last_err_addr !== expLast) begin nMismatch++; $display("[TB] FAIL %s last_err_addr: got %h expected %h", tag, last_err_addr, expLast); end
  endtask

  task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                          input int adelayIn, input int wdelay, input int bdelay);
    int t;
    int adelay;
    logic [3:0] oh;
    t = tbDecode(addr);
    oh = oneHot(t);
    adelay = (t == 4) ? 0 : adelayIn;
    s_awaddr = addr; s_awvalid = 1'b1; s_wdata = data; s_wstrb = strb; s_wvalid = 1'b0;
    m_awready = 4'b0000; m_wready = 4'hF;
    for (int i = 0; i < adelay; i++) begin
      #1;
      nCompared++; if (m_awvalid !== oh) begin nMismatch++; $display("[TB] FAIL aw_wait_steer: got %b expected %b", m_awvalid, oh); end
      nCompared++; if (s_awready !== 1'b0) begin nMismatch++; $display("[TB] FAIL aw_wait_ready: got %b expected 0", s_awready); end
      tick();
    end
    m_awready = oh;
    s_wvalid = (wdelay == 0);
    #1;
    nCompared++; if (m_awvalid !== oh) begin nMismatch++; $display("[TB] FAIL aw_steer: got %b expected %b", m_awvalid, oh); end
    nCompared++; if (s_awready !== 1'b1) begin nMismatch++; $display("[TB] FAIL aw_ready: got %b expected 1", s_awready); end
    nCompared++; if (m_awaddr !== {4{addr}}) begin nMismatch++; $display("[TB] FAIL aw_addr: got %h expected %h", m_awaddr, {4{addr}}); end
    if (wdelay == 0) begin
      nCompared++; if (m_wvalid !== oh) begin nMismatch++; $display("[TB] FAIL w_steer: got %b expected %b", m_wvalid, oh); end
      nCompared++; if (s_wready !== 1'b1) begin nMismatch++; $display("[TB] FAIL w_ready: got %b expected 1", s_wready); end
      nCompared++; if (m_wdata !== {4{data}} || m_wstrb !== {4{strb}}) begin nMismatch++; $display("[TB] FAIL w_payload: got %h/%h expected %h/%h", m_wdata, m_wstrb, {4{data}}, {4{strb}}); end
    end
    tick();
    if (t == 4) noteMiss(addr);
    s_awvalid = 1'b0; s_awaddr = $urandom; s_wvalid = 1'b0;
    if (wdelay > 0) begin
      for (int i = 1; i < wdelay; i++) begin
        #1;
        nCompared++; if (m_wvalid !== 4'b0000) begin nMismatch++; $display("[TB] FAIL w_gap_steer: got %b expected 0000", m_wvalid); end
        tick();
      end
      s_wvalid = 1'b1;
      #1;
      nCompared++; if (m_wvalid !== oh) begin nMismatch++; $display("[TB] FAIL w_late_steer: got %b expected %b", m_wvalid, oh); end
      nCompared++; if (s_wready !== 1'b1) begin nMismatch++; $display("[TB] FAIL w_late_ready: got %b expected 1", s_wready); end
      nCompared++; if (m_wdata !== {4{data}}) begin nMismatch++; $display("[TB] FAIL w_late_data: got %h expected %h", m_wdata, {4{data}}); end
      tick();
      s_wvalid = 1'b0;
    end
    s_bready = 1'b1;
    if (t < 4) begin
      m_bvalid = ~oh;
      for (int i = 0; i < bdelay; i++) begin
        #1;
        nCompared++; if (s_bvalid !== 1'b0) begin nMismatch++; $display("[TB] FAIL b_crosstalk: got %b expected 0", s_bvalid); end
        nCompared++; if (m_bready !== oh) begin nMismatch++; $display("[TB] FAIL b_ready_steer: got %b expected %b", m_bready, oh); end
        nCompared++; if (s_awready !== 1'b0 || s_wready !== 1'b0) begin nMismatch++; $display("[TB] FAIL resp_blocks_req: got %b%b expected 00", s_awready, s_wready); end
        tick();
      end
      m_bvalid = 4'hF;
    end
    #1;
    nCompared++; if (s_bvalid !== 1'b1) begin nMismatch++; $display("[TB] FAIL b_valid: got %b expected 1", s_bvalid); end
    nCompared++; if (m_bready !== oh) begin nMismatch++; $display("[TB] FAIL b_ready: got %b expected %b", m_bready, oh); end
    tick();
    m_bvalid = 4'b0000; s_bready = 1'b0; m_awready = 4'b0000;
    checkCounters("write");
  endtask

  task automatic do_read(input logic [31:0] addr, input int adelayIn, input int rdelay);
    int t;
    int adelay;
    logic [3:0] oh;
    logic [127:0] tbData;
    t = tbDecode(addr);
    oh = oneHot(t);
    adelay = (t == 4) ? 0 : adelayIn;
    tbData = {$urandom, $urandom, $urandom, $urandom};
    m_rdata = tbData;
    s_araddr = addr; s_arvalid = 1'b1; m_arready = 4'b0000;
    for (int i = 0; i < adelay; i++) begin
      #1;
      nCompared++; if (m_arvalid !== oh) begin nMismatch++; $display("[TB] FAIL ar_wait_steer: got %b expected %b", m_arvalid, oh); end
      nCompared++; if (s_arready !== 1'b0) begin nMismatch++; $display("[TB] FAIL ar_wait_ready: got %b expected 0", s_arready); end
      tick();
    end
    m_arready = oh;
    #1;
    nCompared++; if (m_arvalid !== oh) begin nMismatch++; $display("[TB] FAIL ar_steer: got %b expected %b", m_arvalid, oh); end
    nCompared++; if (s_arready !== 1'b1) begin nMismatch++; $display("[TB] FAIL ar_ready: got %b expected 1", s_arready); end
    nCompared++; if (m_araddr !== {4{addr}}) begin nMismatch++; $display("[TB] FAIL ar_addr: got %h expected %h", m_araddr, {4{addr}}); end
    tick();
    if (t == 4) noteMiss(addr);
    s_arvalid = 1'b0; s_rready = 1'b1;
    if (t < 4) begin
      m_rvalid = ~oh;
      for (int i = 0; i < rdelay; i++) begin
        #1;
        nCompared++; if (s_rvalid !== 1'b0) begin nMismatch++; $display("[TB] FAIL r_crosstalk: got %b expected 0", s_rvalid); end
        nCompared++; if (s_arready !== 1'b0) begin nMismatch++; $display("[TB] FAIL r_blocks_ar: got %b expected 0", s_arready); end
        tick();
      end
    end
    m_rvalid = 4'hF;
    #1;
    nCompared++; if (s_rvalid !== 1'b1) begin nMismatch++; $display("[TB] FAIL r_valid: got %b expected 1", s_rvalid); end
    nCompared++; if (s_rdata !== ((t < 4) ? tbData[32*t +: 32] : ERR_DATA)) begin nMismatch++; $display("[TB] FAIL r_data: got %h expected %h", s_rdata, (t < 4) ? tbData[32*t +: 32] : ERR_DATA); end
    nCompared++; if (m_rready !== oh) begin nMismatch++; $display("[TB] FAIL r_ready_steer: got %b expected %b", m_rready, oh); end
    tick();
    m_rvalid = 4'b0000; s_rready = 1'b0; m_arready = 4'b0000;
    checkCounters("read");
  endtask

  task automatic test_reset();
    rst = 1'b1;
    s_awaddr = '0; s_awvalid = 1'b0; s_wdata = '0; s_wstrb = '0; s_wvalid = 1'b0; s_bready = 1'b0;
    s_araddr = 32'h3000_0000; s_arvalid = 1'b1; s_rready = 1'b0;
    m_awready = 4'b0001; m_wready = '0; m_bvalid = 4'hF; m_arready = '0; m_rvalid = 4'hF; m_rdata = '0;
    err_clr = 1'b0;
    tick();
    s_awvalid = 1'b1;
    #1;
    nCompared++; if (m_awvalid !== 4'b0000 || m_arvalid !== 4'b0000) begin nMismatch++; $display("[TB] FAIL reset_valids: got %b/%b expected 0000/0000", m_awvalid, m_arvalid); end
    nCompared++; if (s_bvalid !== 1'b0 || s_rvalid !== 1'b0) begin nMismatch++; $display("[TB] FAIL reset_resp: got %b%b expected 00", s_bvalid, s_rvalid); end
    nCompared++; if (s_awready !== 1'b1 || s_arready !== 1'b1) begin nMismatch++; $display("[TB] FAIL reset_idle_ready: got %b%b expected 11", s_awready, s_arready); end
    checkCounters("reset");
    s_awvalid = 1'b0; s_arvalid = 1'b0; m_awready = '0; m_bvalid = '0; m_rvalid = '0;
    s_araddr = 32'h0000_0000;
    #1;
    nCompared++; if (s_arready !== 1'b0) begin nMismatch++; $display("[TB] FAIL reset_ar_decode: got %b expected 0", s_arready); end
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_mapped_write();
    do_write(32'h1000_0040, 32'hCAFE_F00D, 4'hF, 0, 0, 3);
  endtask

  task automatic test_read_miss();
    do_read(32'h3000_0000, 0, 0);
  endtask

  task automatic test_delayed_w();
    do_write(32'h2000_1004, 32'h1234_5678, 4'h3, 1, 2, 1);
  endtask

  task automatic test_concurrent();
    logic [127:0] tbData;
    tbData = {$urandom, $urandom, $urandom, $urandom};
    m_rdata = tbData;
    s_awaddr = 32'h0000_0100; s_awvalid = 1'b1; s_wdata = 32'h0BAD_F00D; s_wvalid = 1'b1;
    m_awready = 4'b0001; m_wready = 4'hF;
    tick();
    s_awvalid = 1'b0; s_wvalid = 1'b0;
    s_araddr = 32'h2000_0010; s_arvalid = 1'b1; m_arready = 4'b0100;
    #1;
    nCompared++; if (m_arvalid !== 4'b0100 || s_arready !== 1'b1) begin nMismatch++; $display("[TB] FAIL conc_ar: got %b/%b expected 0100/1", m_arvalid, s_arready); end
    tick();
    s_arvalid = 1'b0; s_rready = 1'b1; s_bready = 1'b1; m_rvalid = 4'b0100;
    #1;
    nCompared++; if (s_rvalid !== 1'b1 || s_bvalid !== 1'b0) begin nMismatch++; $display("[TB] FAIL conc_r_first: got r=%b b=%b expected r=1 b=0", s_rvalid, s_bvalid); end
    nCompared++; if (s_rdata !== tbData[95:64]) begin nMismatch++; $display("[TB] FAIL conc_rdata: got %h expected %h", s_rdata, tbData[95:64]); end
    nCompared++; if (m_rready !== 4'b0100 || m_bready !== 4'b0001) begin nMismatch++; $display("[TB] FAIL conc_readies: got %b/%b expected 0100/0001", m_rready, m_bready); end
    tick();
    m_rvalid = 4'b0000; m_bvalid = 4'b0001;
    #1;
    nCompared++; if (s_bvalid !== 1'b1 || s_rvalid !== 1'b0) begin nMismatch++; $display("[TB] FAIL conc_b_second: got b=%b r=%b expected b=1 r=0", s_bvalid, s_rvalid); end
    tick();
    m_bvalid = '0; s_bready = 1'b0; s_rready = 1'b0; m_awready = '0; m_arready = '0;
    checkCounters("concurrent");
  endtask

  task automatic test_dual_miss();
    s_awaddr = 32'h4000_0000; s_awvalid = 1'b1; s_wvalid = 1'b1;
    s_araddr = 32'h5000_0004; s_arvalid = 1'b1;
    #1;
    nCompared++; if (s_awready !== 1'b1 || s_arready !== 1'b1 || s_wready !== 1'b1) begin nMismatch++; $display("[TB] FAIL dual_ready: got %b%b%b expected 111", s_awready, s_wready, s_arready); end
    tick();
    noteMiss(32'h4000_0000);
    noteMiss(32'h5000_0004);
    s_awvalid = 1'b0; s_wvalid = 1'b0; s_arvalid = 1'b0; s_bready = 1'b1; s_rready = 1'b1;
    #1;
    nCompared++; if (s_bvalid !== 1'b1 || s_rvalid !== 1'b1) begin nMismatch++; $display("[TB] FAIL dual_resp: got %b%b expected 11", s_bvalid, s_rvalid); end
    checkCounters("dual_miss");
    tick();
    s_bready = 1'b0; s_rready = 1'b0;
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 256; i++) do_read(32'h3000_0000 + 32'(i * 4), 0, 0);
    nCompared++; if (err_count !== 8'd255) begin nMismatch++; $display("[TB] FAIL sat_hold: got %0d expected 255", err_count); end
    err_clr = 1'b1;
    do_write(32'h6000_0000, 32'h0, 4'h0, 0, 0, 0);
    err_clr = 1'b0;
    nCompared++; if (err_count !== 8'd0) begin nMismatch++; $display("[TB] FAIL sat_clear: got %0d expected 0", err_count); end
  endtask

  task automatic test_reset_mid();
    logic [127:0] tbData;
    tbData = {$urandom, $urandom, $urandom, $urandom};
    m_rdata = tbData;
    s_araddr = 32'h2000_0000; s_arvalid = 1'b1; m_arready = 4'b0100;
    tick();
    s_arvalid = 1'b0; m_rvalid = 4'b0100; s_rready = 1'b0;
    #1;
    nCompared++; if (s_rvalid !== 1'b1) begin nMismatch++; $display("[TB] FAIL mid_pre_rvalid: got %b expected 1", s_rvalid); end
    s_rready = 1'b1;
    #1 rst = 1'b1;
    #1;
    expCount = 0; expLast = '0;
    nCompared++; if (s_rvalid !== 1'b0 || m_rready !== 4'b0000) begin nMismatch++; $display("[TB] FAIL mid_async: got r=%b rr=%b expected 0/0000", s_rvalid, m_rready); end
    checkCounters("reset_mid");
    tick();
    rst = 1'b0; m_rvalid = '0; s_rready = 1'b0; m_arready = '0;
    tick();
    do_read(32'h0000_0000, 1, 1);
  endtask

  task automatic test_random_traffic();
    logic [31:0] addr;
    int kind;
    for (int n = 0; n < 40; n++) begin
      kind = $urandom_range(0, 4);
      case (kind)
        0:       addr = {16'h0000, 16'($urandom)};
        1:       addr = {16'h1000, 16'($urandom)};
        2:       addr = {20'h20000, 12'($urandom)};
        3:       addr = {20'h20001, 12'($urandom)};
        default: addr = $urandom;
      endcase
      if ($urandom_range(0, 1) == 0)
        do_write(addr, $urandom, 4'($urandom), $urandom_range(0, 2), $urandom_range(0, 2), $urandom_range(0, 2));
      else
        do_read(addr, $urandom_range(0, 2), $urandom_range(0, 2));
    end
  endtask

  initial begin
    test_reset();
    test_mapped_write();
    test_read_miss();
    test_delayed_w();
    test_concurrent();
    test_dual_miss();
    test_random_traffic();
    test_saturation();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
    $finish;
  end

endmodule
